// File: rtl/controle_jogo_pkg.sv
// Shared game-sequencer types and renderer geometry constants.
// No logic; no latency; no flow control.
package controle_jogo_pkg;

    typedef enum logic [1:0] {
        ATTRACT  = 2'd0,
        PLAY     = 2'd1,
        HIT      = 2'd2,
        GAMEOVER = 2'd3
    } estado_t;

    localparam int V_ACTIVE_DEF = 480;
    localparam int TOP_ROW_DEF  = 75;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max_v);
        return (v >= max_v) ? max_v : v + 8'd1;
    endfunction

endpackage

// File: rtl/botao_pulso.sv
// Button synchronizer plus per-frame edge detect: pulso marks a new press.
// Latency: 2 clk sync, then evaluated on the next amostra_en cycle.
// No backpressure; pulso is combinational from registered state and amostra_en.
module botao_pulso (
    input  logic clk,
    input  logic reset_n,
    input  logic botao,
    input  logic amostra_en,
    output logic pulso
);
    logic [1:0] sync_q;
    logic       anterior_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b00;
            anterior_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], botao};
            // Sampling only at frame rate doubles as the debounce.
            if (amostra_en)
                anterior_q <= sync_q[1];
        end
    end

    assign pulso = amostra_en && sync_q[1] && !anterior_q;

endmodule

// File: rtl/controle_jogo.sv
// Freeway round sequencer: frame tick, move pulses, collision, score and lives.
// Latency: all outputs registered; updates land in the cycle frame_tick is high.
// No backpressure; renderer must act on one-cycle pulses when they appear.
module controle_jogo
    import controle_jogo_pkg::*;
#(
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int TOP_ROW    = TOP_ROW_DEF,
    parameter int LIVES      = 3,
    parameter int HIT_FRAMES = 30,
    parameter int SCORE_MAX  = 99
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] row,
    input  logic [9:0] column,
    input  logic       cima,
    input  logic       baixo,
    input  logic       saida_galinha,
    input  logic       saida_carro,
    input  logic [9:0] linha_galinha,
    output logic       frame_tick,
    output logic       mover_cima,
    output logic       mover_baixo,
    output logic       reinicia_galinha,
    output logic       congela,
    output logic [7:0] placar,
    output logic [1:0] vidas,
    output logic [1:0] estado
);
    logic cond, cond_q, tick;
    logic press_cima, press_baixo, overlap;

    estado_t    estado_q, estado_d;
    logic [7:0] placar_q, placar_d;
    logic [1:0] vidas_q, vidas_d;
    logic [5:0] cnt_q, cnt_d;
    logic       colisao_q, colisao_d;
    logic       pend_cima_q, pend_cima_d, pend_baixo_q, pend_baixo_d;
    logic       frame_tick_q, congela_q;
    logic       mover_cima_q, mover_cima_d, mover_baixo_q, mover_baixo_d;
    logic       reinicia_q, reinicia_d;

    // Edge-qualified so a scan position held for several cycles still ticks once.
    assign cond    = (row == 10'(V_ACTIVE)) && (column == 10'd0);
    assign tick    = cond && !cond_q;
    assign overlap = saida_galinha && saida_carro;

    botao_pulso u_cima (
        .clk(clk), .reset_n(reset_n), .botao(cima), .amostra_en(tick), .pulso(press_cima)
    );
    botao_pulso u_baixo (
        .clk(clk), .reset_n(reset_n), .botao(baixo), .amostra_en(tick), .pulso(press_baixo)
    );

    always_comb begin
        estado_d      = estado_q;
        placar_d      = placar_q;
        vidas_d       = vidas_q;
        cnt_d         = cnt_q;
        pend_cima_d   = pend_cima_q;
        pend_baixo_d  = pend_baixo_q;
        mover_cima_d  = 1'b0;
        mover_baixo_d = 1'b0;
        reinicia_d    = 1'b0;
        colisao_d     = colisao_q || (overlap && estado_q == PLAY);
        if (tick) begin
            colisao_d = 1'b0;
            case (estado_q)
                ATTRACT: begin
                    pend_cima_d  = 1'b0;
                    pend_baixo_d = 1'b0;
                    if (press_cima || press_baixo)
                        estado_d = PLAY;
                end
                PLAY: begin
                    if (colisao_q || overlap) begin
                        estado_d     = HIT;
                        cnt_d        = 6'(HIT_FRAMES);
                        pend_cima_d  = 1'b0;
                        pend_baixo_d = 1'b0;
                    end else begin
                        if (linha_galinha <= 10'(TOP_ROW)) begin
                            placar_d   = sat_inc(placar_q, 8'(SCORE_MAX));
                            reinicia_d = 1'b1;
                        end else begin
                            mover_cima_d  = pend_cima_q;
                            mover_baixo_d = pend_baixo_q;
                        end
                        // Opposite presses in the same frame cancel each other.
                        pend_cima_d  = press_cima && !press_baixo;
                        pend_baixo_d = press_baixo && !press_cima;
                    end
                end
                HIT: begin
                    pend_cima_d  = 1'b0;
                    pend_baixo_d = 1'b0;
                    cnt_d        = cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        reinicia_d = 1'b1;
                        vidas_d    = vidas_q - 2'd1;
                        estado_d   = (vidas_q == 2'd1) ? GAMEOVER : PLAY;
                    end
                end
                GAMEOVER: begin
                    pend_cima_d  = 1'b0;
                    pend_baixo_d = 1'b0;
                    if (press_cima || press_baixo) begin
                        vidas_d  = 2'(LIVES);
                        placar_d = 8'd0;
                        estado_d = ATTRACT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cond_q        <= 1'b0;
            estado_q      <= ATTRACT;
            placar_q      <= 8'd0;
            vidas_q       <= 2'(LIVES);
            cnt_q         <= 6'd0;
            colisao_q     <= 1'b0;
            pend_cima_q   <= 1'b0;
            pend_baixo_q  <= 1'b0;
            frame_tick_q  <= 1'b0;
            congela_q     <= 1'b1;
            mover_cima_q  <= 1'b0;
            mover_baixo_q <= 1'b0;
            reinicia_q    <= 1'b0;
        end else begin
            cond_q        <= cond;
            estado_q      <= estado_d;
            placar_q      <= placar_d;
            vidas_q       <= vidas_d;
            cnt_q         <= cnt_d;
            colisao_q     <= colisao_d;
            pend_cima_q   <= pend_cima_d;
            pend_baixo_q  <= pend_baixo_d;
            frame_tick_q  <= tick;
            congela_q     <= (estado_d != PLAY);
            mover_cima_q  <= mover_cima_d;
            mover_baixo_q <= mover_baixo_d;
            reinicia_q    <= reinicia_d;
        end
    end

    assign frame_tick       = frame_tick_q;
    assign mover_cima       = mover_cima_q;
    assign mover_baixo      = mover_baixo_q;
    assign reinicia_galinha = reinicia_q;
    assign congela          = congela_q;
    assign placar           = placar_q;
    assign vidas            = vidas_q;
    assign estado           = estado_q;

endmodule

// File: tb/tb_controle_jogo.sv
// Bench for controle_jogo: compressed 8-row x 4-column scan around row 480,
// per-frame behavioural model of the round rules.
module tb_controle_jogo;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] row, column, linha_galinha;
    logic       cima, baixo, saida_galinha, saida_carro;
    logic       frame_tick, mover_cima, mover_baixo, reinicia_galinha, congela;
    logic [7:0] placar;
    logic [1:0] vidas, estado;

    int total = 0;
    int bad   = 0;

    // Model state: one step per frame.
    int m_estado, m_placar, m_vidas, m_cnt;
    bit m_prev_c, m_prev_b, m_pc, m_pb, e_mc, e_mb, e_rg;
    logic [18:0] obs, expv;

    always #5 clk = ~clk;

    controle_jogo dut (
        .clk(clk), .reset_n(reset_n), .row(row), .column(column),
        .cima(cima), .baixo(baixo), .saida_galinha(saida_galinha),
        .saida_carro(saida_carro), .linha_galinha(linha_galinha),
        .frame_tick(frame_tick), .mover_cima(mover_cima), .mover_baixo(mover_baixo),
        .reinicia_galinha(reinicia_galinha), .congela(congela), .placar(placar),
        .vidas(vidas), .estado(estado)
    );

    task automatic model_reset();
        m_estado = 0; m_placar = 0; m_vidas = 3; m_cnt = 0;
        m_prev_c = 0; m_prev_b = 0; m_pc = 0; m_pb = 0;
        e_mc = 0; e_mb = 0; e_rg = 0;
    endtask

    task automatic model_tick(input bit c, input bit b, input bit hit, input int linha);
        bit pc, pb;
        pc = c && !m_prev_c;
        pb = b && !m_prev_b;
        m_prev_c = c;
        m_prev_b = b;
        e_mc = 0; e_mb = 0; e_rg = 0;
        case (m_estado)
            0: begin
                if (pc || pb) m_estado = 1;
                m_pc = 0; m_pb = 0;
            end
            1: begin
                if (hit) begin
                    m_estado = 2; m_cnt = 30; m_pc = 0; m_pb = 0;
                end else begin
                    if (linha <= 75) begin
                        m_placar = (m_placar >= 99) ? 99 : m_placar + 1;
                        e_rg = 1;
                    end else begin
                        e_mc = m_pc; e_mb = m_pb;
                    end
                    m_pc = pc && !pb;
                    m_pb = pb && !pc;
                end
            end
            2: begin
                m_pc = 0; m_pb = 0;
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    e_rg = 1;
                    m_vidas = m_vidas - 1;
                    m_estado = (m_vidas == 0) ? 3 : 1;
                end
            end
            default: begin
                if (pc || pb) begin
                    m_vidas = 3; m_placar = 0; m_estado = 0;
                end
            end
        endcase
        expv = {2'd1, 1'b0, 2'(m_estado), 8'(m_placar), 2'(m_vidas),
                (m_estado != 1), e_mc, e_mb, e_rg};
    endtask

    // Drives one 32-cycle frame; the tick position is row 480, column 0 (cycle 16).
    task automatic do_frame(input bit c, input bit b, input bit hit, input logic [9:0] linha);
        int nt;
        bit stray, mhit;
        logic [15:0] cap;
        nt = 0; stray = 0; cap = '0;
        mhit = hit && (m_estado == 1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (frame_tick) begin
                nt++;
                cap = {estado, placar, vidas, congela, mover_cima, mover_baixo, reinicia_galinha};
            end else if (mover_cima || mover_baixo || reinicia_galinha) begin
                stray = 1;
            end
            row           = 10'(476 + i / 4);
            column        = 10'(i % 4);
            cima          = c;
            baixo         = b;
            linha_galinha = linha;
            saida_galinha = hit && (i == 5);
            saida_carro   = hit && (i == 5);
        end
        obs = {2'(nt), stray, cap};
        model_tick(c, b, mhit, int'(linha));
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        cima = 0; baixo = 0; saida_galinha = 0; saida_carro = 0;
        row = 10'd0; column = 10'd0; linha_galinha = 10'd300;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cima = 0; baixo = 0; saida_galinha = 0; saida_carro = 0;
        row = 10'd0; column = 10'd0; linha_galinha = 10'd300;
        repeat (3) @(negedge clk);
        total++;
        if ({frame_tick, estado, placar, vidas, congela, mover_cima, mover_baixo, reinicia_galinha}
            !== {1'b0, 2'd0, 8'd0, 2'd3, 1'b1, 3'b000}) begin
            bad++;
            $display("FAIL reset_values: got %b want %b",
                {frame_tick, estado, placar, vidas, congela, mover_cima, mover_baixo, reinicia_galinha},
                {1'b0, 2'd0, 8'd0, 2'd3, 1'b1, 3'b000});
        end
        reset_n = 1'b1;
        model_reset();
        do_frame(0, 0, 0, 10'd300);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL reset_first_frame: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_attract();
        bit pat[16] = '{1,1,1,0, 1,1,1,1,1,1,1,1,1,1, 0,0};
        int n_mc = 0;
        for (int f = 0; f < 16; f++) begin
            do_frame(pat[f], 0, 0, 10'd300);
            if (f >= 4) n_mc += int'(obs[2]);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL attract frame %0d: got %h want %h", f, obs, expv);
            end
        end
        total++;
        if (n_mc !== 1) begin
            bad++;
            $display("FAIL attract_single_step: got %0d mover_cima want 1", n_mc);
        end
    endtask

    task automatic test_simul();
        int n_mv = 0;
        for (int f = 0; f < 4; f++) begin
            do_frame(f == 0, f == 0, 0, 10'd300);
            n_mv += int'(obs[2]) + int'(obs[1]);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL simul frame %0d: got %h want %h", f, obs, expv);
            end
        end
        total++;
        if (n_mv !== 0) begin
            bad++;
            $display("FAIL simul_no_move: got %0d moves want 0", n_mv);
        end
    endtask

    task automatic test_collision();
        for (int f = 0; f < 31; f++) begin
            do_frame(f > 0 && $urandom_range(0, 1) == 1, f > 0 && $urandom_range(0, 1) == 1,
                     f == 0, 10'd300);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL collision frame %0d: got %h want %h", f, obs, expv);
            end
        end
        total++;
        if ({obs[15:14], obs[5:4], obs[0]} !== {2'd1, 2'd2, 1'b1}) begin
            bad++;
            $display("FAIL collision_exit: got estado=%0d vidas=%0d reinicia=%0d want 1 2 1",
                     obs[15:14], obs[5:4], obs[0]);
        end
    endtask

    task automatic test_score();
        for (int f = 0; f < 101; f++) begin
            do_frame(0, 0, 0, 10'd75);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL score frame %0d: got %h want %h", f, obs, expv);
            end
        end
        total++;
        if (obs[13:6] !== 8'd99) begin
            bad++;
            $display("FAIL score_saturate: got %0d want 99", obs[13:6]);
        end
        for (int f = 0; f < 31; f++) begin
            do_frame(0, 0, f == 0, 10'd75);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL score_vs_hit frame %0d: got %h want %h", f, obs, expv);
            end
        end
    endtask

    task automatic test_gameover();
        apply_reset();
        do_frame(0, 1, 0, 10'd300);
        for (int f = 0; f < 93; f++) begin
            do_frame(0, 0, (f % 31) == 0, 10'd300);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL gameover frame %0d: got %h want %h", f, obs, expv);
            end
        end
        total++;
        if ({obs[15:14], obs[5:4], obs[3]} !== {2'd3, 2'd0, 1'b1}) begin
            bad++;
            $display("FAIL gameover_state: got estado=%0d vidas=%0d want 3 0", obs[15:14], obs[5:4]);
        end
        do_frame(0, 1, 0, 10'd300);
        total++;
        if ({obs[15:14], obs[13:6], obs[5:4]} !== {2'd0, 8'd0, 2'd3} || obs !== expv) begin
            bad++;
            $display("FAIL gameover_restart: got %h want %h", obs, expv);
        end
    endtask

    task automatic test_random();
        logic [9:0] linhas[5] = '{10'd75, 10'd74, 10'd76, 10'd300, 10'd10};
        for (int f = 0; f < 400; f++) begin
            do_frame($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 9) == 0, linhas[$urandom_range(0, 4)]);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL random frame %0d: got %h want %h", f, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid_hit();
        int guard = 0;
        while (m_estado != 2 && guard < 200) begin
            do_frame((m_estado != 1) && (guard % 2 == 0), 0, m_estado == 1, 10'd300);
            guard++;
        end
        total++;
        if (m_estado != 2 || obs !== expv) begin
            bad++;
            $display("FAIL reach_hit: got %h want %h after %0d frames", obs, expv, guard);
        end
        repeat (5) do_frame(0, 0, 0, 10'd300);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({estado, placar, vidas, congela, mover_cima, mover_baixo, reinicia_galinha, frame_tick}
            !== {2'd0, 8'd0, 2'd3, 1'b1, 4'b0000}) begin
            bad++;
            $display("FAIL reset_mid_hit: got estado=%0d placar=%0d vidas=%0d congela=%0d",
                     estado, placar, vidas, congela);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        do_frame(0, 0, 0, 10'd300);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL after_reset_frame: got %h want %h", obs, expv);
        end
    endtask

    initial begin
        test_reset();
        test_attract();
        test_simul();
        test_collision();
        test_score();
        test_gameover();
        test_random();
        test_reset_mid_hit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_jogo.md
Name: controle_jogo

Overview:
Game sequencer for the freeway renderer. Derives a once-per-frame tick from the VGA scan position and turns raw up/down buttons into single-step move pulses per press. Latches pixel-level chicken/vehicle overlap and runs the round state machine: attract, play, hit freeze, game over. Owns score and lives, and drives the chicken-reset and vehicle-freeze controls of the renderer.

Parameters:
V_ACTIVE, 480, first non-visible row; frame tick fires at row==V_ACTIVE, column==0
TOP_ROW, 75, chicken row at or above which a crossing is scored
LIVES, 3, lives loaded at reset and on leaving GAMEOVER (1..3)
HIT_FRAMES, 30, frames frozen after a collision (1..63)
SCORE_MAX, 99, score saturation value

Ports:
clk  in  1  pixel clock, same as renderer
reset_n  in  1  asynchronous, active-low reset
row  in  10  current scan row
column  in  10  current scan column
cima  in  1  raw up button, asynchronous
baixo  in  1  raw down button, asynchronous
saida_galinha  in  1  renderer chicken pixel flag
saida_carro  in  1  renderer vehicle pixel flag
linha_galinha  in  10  chicken top row currently applied by renderer
frame_tick  out  1  one-cycle pulse per frame
mover_cima  out  1  one-cycle move-up command, coincident with frame_tick
mover_baixo  out  1  one-cycle move-down command, coincident with frame_tick
reinicia_galinha  out  1  one-cycle command returning chicken to start row
congela  out  1  level; 1 = vehicles hold position
placar  out  8  score, binary
vidas  out  2  lives remaining
estado  out  2  0 ATTRACT, 1 PLAY, 2 HIT, 3 GAMEOVER

Behaviour:
- Reset (async assert, sync release): estado=ATTRACT, placar=0, vidas=LIVES, congela=1, all pulses 0, hit latch/requests/counters cleared. Reset mid-frame or mid-HIT aborts immediately.
- Frame tick: registered pulse on the first cycle where row==V_ACTIVE && column==0. Never two ticks in consecutive cycles.
- Buttons: 2-flop synchronizer each, then sampled only on frame_tick (frame-rate debounce). A press = sampled 1 where previous sample 0. A press sets a pending request, issued on the next frame_tick. At most one step per press; holding gives no repeat. Simultaneous cima and baixo presses issue neither.
- Collision latch: set on any cycle with saida_galinha && saida_carro while estado==PLAY. Sampled and cleared on every frame_tick.
- All state updates happen on frame_tick; outputs are registered, and pulses are asserted in the cycle after the tick condition, aligned with frame_tick.
- ATTRACT: congela=1. Any button press goes to PLAY. That press produces no move.
- PLAY: congela=0. At each tick, in priority order:
  - Collision latched: go to HIT, load hit counter=HIT_FRAMES, drop pending requests, no move.
  - Else if linha_galinha <= TOP_ROW: placar+1, saturating at SCORE_MAX; assert reinicia_galinha; no move.
  - Else issue mover_cima or mover_baixo per pending request.
- HIT: congela=1. Counter decrements per tick; buttons are ignored and the latch is held clear. On the tick where the counter reaches 0: assert reinicia_galinha and vidas-1. If vidas was 1, go to GAMEOVER (vidas=0); else go to PLAY.
- GAMEOVER: congela=1; placar held. A button press loads vidas=LIVES, placar=0, and goes to ATTRACT.
- Collision and goal on the same tick: collision wins, no score.

Decomposition:
- Shared package: estado encodings, default V_ACTIVE/TOP_ROW constants (shared with renderer).
- One sub-module: botao_pulso (synchronizer + per-tick edge detect), instantiated twice.

Test Plan:
- Reset, run one frame -> exactly one frame_tick at row 480/col 0; estado=0, vidas=3, placar=0, congela=1.
- ATTRACT: pulse cima for 3 frames -> estado=1 after next tick, no mover_cima. Then press cima once held 10 frames -> exactly one mover_cima.
- PLAY: press cima and baixo in the same frame -> no move pulse on either.
- PLAY: force saida_galinha=saida_carro=1 for one cycle mid-frame -> next tick estado=2, congela=1. After 30 ticks: reinicia_galinha pulse, vidas=2, estado=1.
- PLAY: set linha_galinha=75 -> placar 0->1 with reinicia_galinha. With placar=99 -> stays 99. Collision in the same frame -> HIT, placar unchanged.
- Three collisions -> estado=3, vidas=0. Press baixo -> estado=0, vidas=3, placar=0. Assert reset_n mid-HIT -> immediate ATTRACT.
